// File: rtl/sdram_stub_pkg.sv
// Shared types and helpers for the on-chip SDRAM controller stand-in.
package sdram_stub_pkg;

    typedef enum logic [1:0] {IDLE, WRITE, READ, REFRESH} stub_state_t;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int BYTE_SHIFT = $clog2(DEF_DATA_WIDTH / 8);

    function automatic logic [63:0] word_index(
        input logic [63:0] addr,
        input int          shift = BYTE_SHIFT
    );
        return addr >> shift;
    endfunction

endpackage

// File: rtl/sdram_ctrl_if.sv
// Request/response bus between a bus master and an SDRAM controller.
interface sdram_ctrl_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] write_data;
    logic                  wr;
    logic                  rd;
    logic                  rdy;
    logic                  wvalid;
    logic                  rvalid;
    logic [DATA_WIDTH-1:0] read_data;

    modport man (
        input  addr, write_data, wr, rd,
        output rdy, wvalid, rvalid, read_data
    );

    modport sub (
        output addr, write_data, wr, rd,
        input  rdy, wvalid, rvalid, read_data
    );
endinterface

// File: rtl/sdram_stub_mem.sv
// Single-port synchronous RAM; the read port only updates when re_i is high.
module sdram_stub_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_BITS  = 10
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  we_i,
    input  logic                  re_i,
    input  logic [ADDR_BITS-1:0]  addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);
    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_BITS];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/sdram_ctrl_stub.sv
// RAM-backed responder for sdram_ctrl_if with configurable latency and refresh stalls.
module sdram_ctrl_stub
    import sdram_stub_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int MEM_WORDS_LOG2 = 10,
    parameter int WR_LATENCY     = 3,
    parameter int RD_LATENCY     = 5,
    parameter int REFRESH_PERIOD = 0,
    parameter int REFRESH_CYCLES = 4
) (
    input  logic      clk,
    input  logic      rst,
    sdram_ctrl_if.man ctrl_if,
    output logic      proto_err
);
    localparam int BSH  = $clog2(DATA_WIDTH / 8);
    localparam int LWR  = (WR_LATENCY > RD_LATENCY) ? WR_LATENCY : RD_LATENCY;
    localparam int LMAX = (LWR > REFRESH_CYCLES) ? LWR : REFRESH_CYCLES;
    localparam int CW   = $clog2(LMAX) + 1;
    localparam int RW   = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;
    localparam int MW   = MEM_WORDS_LOG2;

    localparam logic [CW-1:0] WR_LAST = CW'(WR_LATENCY - 1);
    localparam logic [CW-1:0] RD_LAST = CW'(RD_LATENCY - 1);
    localparam logic [CW-1:0] RF_LAST = CW'(REFRESH_CYCLES - 1);
    localparam logic [CW-1:0] WR_PRE  = CW'((WR_LATENCY > 1) ? WR_LATENCY - 2 : 0);
    localparam logic [CW-1:0] RD_PRE  = CW'((RD_LATENCY > 1) ? RD_LATENCY - 2 : 0);
    localparam logic [RW-1:0] REF_LAST =
        (REFRESH_PERIOD > 0) ? RW'(REFRESH_PERIOD - 1) : '0;

    stub_state_t           state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [RW-1:0]         ref_q, ref_d;
    logic                  pend_q, pend_d;
    logic                  rdy_q, rdy_d;
    logic                  perr_q, perr_d;
    logic [MW-1:0]         idx_q, idx_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

    logic [63:0]           idx_full;
    logic [MW-1:0]         req_idx;
    logic [MW-1:0]         mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_we, mem_re;
    logic                  accept, wrap;

    assign idx_full = word_index(64'(ctrl_if.addr), BSH);
    assign req_idx  = idx_full[MW-1:0];
    assign accept   = rdy_q && (ctrl_if.wr || ctrl_if.rd);
    assign wrap     = (REFRESH_PERIOD != 0) && (ref_q == REF_LAST);
    assign ref_d    = (REFRESH_PERIOD == 0 || wrap) ? '0 : ref_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        pend_d    = pend_q | wrap;
        perr_d    = perr_q;
        idx_d     = idx_q;
        wdata_d   = wdata_q;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_addr  = idx_q;
        mem_wdata = wdata_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    cnt_d   = '0;
                    idx_d   = req_idx;
                    wdata_d = ctrl_if.write_data;
                    if (ctrl_if.wr) begin
                        state_d = WRITE;
                        perr_d  = perr_q | ctrl_if.rd;
                        // single-cycle latency commits straight from the bus
                        if (WR_LATENCY == 1) begin
                            mem_we    = 1'b1;
                            mem_addr  = req_idx;
                            mem_wdata = ctrl_if.write_data;
                        end
                    end else begin
                        state_d = READ;
                        if (RD_LATENCY == 1) begin
                            mem_re   = 1'b1;
                            mem_addr = req_idx;
                        end
                    end
                end else if (pend_d) begin
                    state_d = REFRESH;
                    cnt_d   = '0;
                end
            end
            WRITE: begin
                mem_we = (WR_LATENCY > 1) && (cnt_q == WR_PRE);
                if (cnt_q == WR_LAST) begin
                    state_d = pend_d ? REFRESH : IDLE;
                    cnt_d   = '0;
                end
            end
            READ: begin
                mem_re = (RD_LATENCY > 1) && (cnt_q == RD_PRE);
                if (cnt_q == RD_LAST) begin
                    state_d = pend_d ? REFRESH : IDLE;
                    cnt_d   = '0;
                end
            end
            REFRESH: begin
                if (cnt_q == RF_LAST) begin
                    pend_d  = wrap;
                    state_d = wrap ? REFRESH : IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        rdy_d = (state_d == IDLE) && !pend_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ref_q   <= '0;
            pend_q  <= 1'b0;
            rdy_q   <= 1'b0;
            perr_q  <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ref_q   <= ref_d;
            pend_q  <= pend_d;
            rdy_q   <= rdy_d;
            perr_q  <= perr_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
        end
    end

    sdram_stub_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_BITS  (MW)
    ) u_mem (
        .clk_i   (clk),
        .rst_i   (rst),
        .we_i    (mem_we && !rst),
        .re_i    (mem_re),
        .addr_i  (mem_addr),
        .wdata_i (mem_wdata),
        .rdata_o (mem_rdata)
    );

    assign ctrl_if.rdy       = rdy_q;
    assign ctrl_if.wvalid    = (state_q == WRITE) && (cnt_q == WR_LAST);
    assign ctrl_if.rvalid    = (state_q == READ) && (cnt_q == RD_LAST);
    assign ctrl_if.read_data = mem_rdata;
    assign proto_err         = perr_q;
endmodule

// File: tb/tb_sdram_ctrl_stub.sv
// Directed bench for sdram_ctrl_stub: default instance plus a refresh/latency-1 instance.
module tb_sdram_ctrl_stub;

    logic clk = 1'b0;
    logic rst0 = 1'b1;
    logic rst1 = 1'b1;
    logic perr0, perr1;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    sdram_ctrl_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus0 ();
    sdram_ctrl_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus1 ();

    sdram_ctrl_stub u0 (
        .clk       (clk),
        .rst       (rst0),
        .ctrl_if   (bus0),
        .proto_err (perr0)
    );

    sdram_ctrl_stub #(
        .WR_LATENCY     (1),
        .RD_LATENCY     (1),
        .REFRESH_PERIOD (20),
        .REFRESH_CYCLES (4)
    ) u1 (
        .clk       (clk),
        .rst       (rst1),
        .ctrl_if   (bus1),
        .proto_err (perr1)
    );

    typedef struct {
        logic        w;
        logic        r;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp;
        logic        perr;
    } vec_t;

    vec_t vt[35];

    task automatic check(input string nm, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d] got=%0h expected=%0h", nm, idx, act, exp);
        end
    endtask

    task automatic wait_rdy0(input int idx);
        int n;
        n = 0;
        while (bus0.rdy !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("rdy_wait", idx, 32'(bus0.rdy), 32'd1);
    endtask

    task automatic do_op(input int idx, input logic w, input logic r,
                         input logic [31:0] a, input logic [31:0] d,
                         output int wlat, output int rlat,
                         output int wn, output int rn,
                         output logic [31:0] rdat);
        bus0.wr = w;
        bus0.rd = r;
        bus0.addr = a;
        bus0.write_data = d;
        wait_rdy0(idx);
        @(posedge clk); #1;
        bus0.wr = 1'b0;
        bus0.rd = 1'b0;
        check("rdy_low_after_accept", idx, 32'(bus0.rdy), 32'd0);
        wlat = 0; rlat = 0; wn = 0; rn = 0; rdat = '0;
        for (int k = 1; k <= 12; k++) begin
            if (bus0.wvalid) begin
                wn++;
                if (wlat == 0) wlat = k;
            end
            if (bus0.rvalid) begin
                rn++;
                if (rlat == 0) begin
                    rlat = k;
                    rdat = bus0.read_data;
                end
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int wlat, rlat, wn, rn;
        logic [31:0] rdat;
        logic [12:0] patr, patv, expr, expv;
        logic wseen;
        int acc_n, cyc, lowrun, long_runs, odd_runs, wn1, rn1;
        logic take;
        int q[$];
        logic [31:0] expd;

        for (int i = 0; i < 15; i++) begin
            vt[i] = '{1'b1, 1'b0, 32'(i * 4), 32'(i), 32'h0, 1'b0};
            vt[15 + i] = '{1'b0, 1'b1, 32'(i * 4), 32'h0, 32'(i), 1'b0};
        end
        vt[30] = '{1'b1, 1'b0, 32'h0080_0000, 32'hF, 32'h0, 1'b0};
        vt[31] = '{1'b0, 1'b1, 32'h0, 32'h0, 32'hF, 1'b0};
        vt[32] = '{1'b0, 1'b1, 32'h3, 32'h0, 32'hF, 1'b0};
        vt[33] = '{1'b1, 1'b1, 32'h10, 32'hAA, 32'h0, 1'b1};
        vt[34] = '{1'b0, 1'b1, 32'h10, 32'h0, 32'hAA, 1'b1};

        bus0.wr = 0; bus0.rd = 0; bus0.addr = 0; bus0.write_data = 0;
        bus1.wr = 0; bus1.rd = 0; bus1.addr = 0; bus1.write_data = 0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_rdy", 0, 32'(bus0.rdy), 0);
        check("rst_wvalid", 0, 32'(bus0.wvalid), 0);
        check("rst_rvalid", 0, 32'(bus0.rvalid), 0);
        check("rst_rdata", 0, bus0.read_data, 0);
        check("rst_perr", 0, 32'(perr0), 0);
        check("rst_rdy", 1, 32'(bus1.rdy), 0);
        rst0 = 1'b0;
        rst1 = 1'b0;
        @(posedge clk); #1;
        check("rdy_after_rst", 0, 32'(bus0.rdy), 1);

        for (int i = 0; i < 35; i++) begin
            do_op(i, vt[i].w, vt[i].r, vt[i].a, vt[i].d, wlat, rlat, wn, rn, rdat);
            if (vt[i].w) begin
                check("wr_lat", i, 32'(wlat), 3);
                check("wr_pulses", i, 32'(wn), 1);
                check("wr_no_rvalid", i, 32'(rn), 0);
            end else begin
                check("rd_lat", i, 32'(rlat), 5);
                check("rd_pulses", i, 32'(rn), 1);
                check("rd_data", i, rdat, vt[i].exp);
                check("rd_hold", i, bus0.read_data, vt[i].exp);
            end
            check("perr", i, 32'(perr0), 32'(vt[i].perr));
        end

        // continuous read request: rdy back one cycle after each rvalid
        bus0.addr = 32'h8;
        bus0.rd = 1'b1;
        wait_rdy0(100);
        patr = '0; patv = '0; expr = '0; expv = '0;
        for (int k = 0; k <= 12; k++) begin
            patr[k] = bus0.rdy;
            patv[k] = bus0.rvalid;
            expr[k] = (k % 6 == 0);
            expv[k] = (k % 6 == 5);
            if (bus0.rvalid) check("t6_data", k, bus0.read_data, 32'd2);
            if (k == 12) bus0.rd = 1'b0;
            @(posedge clk); #1;
        end
        check("t6_rdy_pattern", 0, 32'(patr), 32'(expr));
        check("t6_rvalid_pattern", 0, 32'(patv), 32'(expv));

        // reset two cycles into a write; word 8 must keep its value
        repeat (8) @(posedge clk);
        #1;
        bus0.wr = 1'b1;
        bus0.addr = 32'h20;
        bus0.write_data = 32'h55;
        wait_rdy0(101);
        @(posedge clk); #1;
        bus0.wr = 1'b0;
        wseen = 1'b0;
        @(posedge clk); #1;
        wseen |= bus0.wvalid;
        rst0 = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            wseen |= bus0.wvalid;
            check("t5_rst_rdy", k, 32'(bus0.rdy), 0);
            check("t5_rst_wvalid", k, 32'(bus0.wvalid), 0);
            check("t5_rst_rvalid", k, 32'(bus0.rvalid), 0);
            check("t5_rst_rdata", k, bus0.read_data, 0);
            check("t5_rst_perr", k, 32'(perr0), 0);
        end
        rst0 = 1'b0;
        @(posedge clk); #1;
        check("t5_rdy_release", 0, 32'(bus0.rdy), 1);
        for (int k = 0; k < 5; k++) begin
            wseen |= bus0.wvalid;
            @(posedge clk); #1;
        end
        check("t5_no_wvalid", 0, 32'(wseen), 0);
        do_op(102, 1'b0, 1'b1, 32'h20, 32'h0, wlat, rlat, wn, rn, rdat);
        check("t5_old_value", 0, rdat, 32'd8);

        // refresh instance: held back-to-back writes then reads
        acc_n = 0; cyc = 0; lowrun = 0; long_runs = 0; odd_runs = 0;
        wn1 = 0; rn1 = 0;
        while (acc_n < 24 && cyc < 400) begin
            bus1.wr = (acc_n < 8);
            bus1.rd = (acc_n >= 8);
            bus1.addr = 32'((acc_n % 8) * 4);
            bus1.write_data = 32'h100 + 32'(acc_n);
            take = bus1.rdy;
            if (take && acc_n >= 8) q.push_back(acc_n % 8);
            @(posedge clk); #1;
            cyc++;
            if (take) acc_n++;
            if (bus1.wvalid) wn1++;
            if (bus1.rvalid) begin
                rn1++;
                expd = (q.size() > 0) ? 32'h100 + 32'(q.pop_front()) : 32'hDEAD;
                check("t4_data", rn1, bus1.read_data, expd);
            end
            if (acc_n > 0) begin
                if (!bus1.rdy) begin
                    lowrun++;
                end else if (lowrun > 0) begin
                    if (lowrun == 5) long_runs++;
                    else if (lowrun != 1) odd_runs++;
                    lowrun = 0;
                end
            end
        end
        bus1.wr = 1'b0;
        bus1.rd = 1'b0;
        check("t4_accepts", 0, 32'(acc_n), 24);
        check("t4_wvalids", 0, 32'(wn1), 8);
        check("t4_rvalids", 0, 32'(rn1), 16);
        check("t4_odd_stalls", 0, 32'(odd_runs), 0);
        check("t4_refresh_seen", 0, 32'(long_runs > 0), 1);
        check("t4_perr", 0, 32'(perr1), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
